// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RISC-V funct3 size/sign codes, the response cause codes and the
// control FSM state encoding used by mem_lsu and lsu_align.
package lsu_pkg;

    // funct3 size/sign codes as carried on req_funct3
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    // resp_cause encodings
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    // control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   funct3    - size/sign code of the access
//   offset    - byte offset of the access inside the memory word
//   we        - 1 for a store, 0 for a load
//   wdata     - right-aligned store data from the core
//   rdata     - full word returned by memory
//   illegal   - funct3 not allowed for this direction / XLEN
//   misalign  - access crosses its natural alignment
//   wstrb     - byte enables (all ones for loads)
//   wdata_rep - store data replicated across every lane of its size
//   rdata_ext - lane at offset, sign- or zero-extended to XLEN
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic                       we,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic                       illegal,
    output logic                       misalign,
    output logic [XLEN/8-1:0]          wstrb,
    output logic [XLEN-1:0]            wdata_rep,
    output logic [XLEN-1:0]            rdata_ext
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;

    // Legality and alignment checks; illegal codes are flagged regardless of
    // the address so the caller can give them priority.
    always_comb begin
        illegal = 1'b0;
        if (funct3 == 3'b111) begin
            illegal = 1'b1;
        end
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
        if ((XLEN == 32) && ((funct3 == LSU_D) || (funct3 == LSU_WU))) begin
            illegal = 1'b1;
        end

        misalign = 1'b0;
        case (funct3)
            LSU_H, LSU_HU: misalign = offset[0];
            LSU_W, LSU_WU: misalign = (offset[1:0] != 2'b00);
            LSU_D:         misalign = (offset != '0);
            default:       misalign = 1'b0;
        endcase
    end

    // Store lane placement: data is replicated so that the strobe alone
    // selects the destination bytes.
    always_comb begin
        wstrb     = '1;
        wdata_rep = wdata;
        if (we) begin
            case (funct3)
                LSU_B: begin
                    wstrb     = NB'(1) << offset;
                    wdata_rep = {NB{wdata[7:0]}};
                end
                LSU_H: begin
                    wstrb     = NB'(2'b11) << offset;
                    wdata_rep = {(NB/2){wdata[15:0]}};
                end
                LSU_W: begin
                    wstrb     = NB'(4'hF) << offset;
                    wdata_rep = {(NB/4){wdata[31:0]}};
                end
                default: begin
                    wstrb     = '1;
                    wdata_rep = wdata;
                end
            endcase
        end
    end

    // Load lane extraction: bring the addressed lane down to bit 0, then
    // extend according to the signedness encoded in funct3[2].
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            LSU_B:   rdata_ext = XLEN'(signed'(shifted[7:0]));
            LSU_H:   rdata_ext = XLEN'(signed'(shifted[15:0]));
            LSU_W:   rdata_ext = XLEN'(signed'(shifted[31:0]));
            LSU_BU:  rdata_ext = XLEN'(shifted[7:0]);
            LSU_HU:  rdata_ext = XLEN'(shifted[15:0]);
            LSU_WU:  rdata_ext = XLEN'(shifted[31:0]);
            LSU_D:   rdata_ext = shifted;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the core control FSM and a valid/ready memory port.
// Adds wait-state tolerance, byte-strobe stores, load extension, alignment
// and funct3 checking, and a watchdog on the memory handshake.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req_valid/req_ready            - core request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                      - request attributes
//   resp_valid, resp_rdata,
//   resp_err, resp_cause           - one-cycle response strobe and payload
//   mem_valid/mem_ready            - memory handshake
//   mem_we, mem_addr, mem_wdata,
//   mem_wstrb, mem_rdata           - memory request payload and read data
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic [1:0]          resp_cause,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  offset_q;
    logic [7:0]        wait_cnt;

    logic [2:0]        sel_funct3;
    logic [OFF_W-1:0]  sel_offset;
    logic              sel_we;
    logic              illegal;
    logic              misalign;
    logic [NB-1:0]     wstrb;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   rdata_ext;

    // One lane unit is shared: in IDLE it checks the incoming request, in
    // MEM it extracts the load lane using the latched attributes.
    always_comb begin
        sel_funct3 = (state == ST_IDLE) ? req_funct3 : funct3_q;
        sel_offset = (state == ST_IDLE) ? req_addr[OFF_W-1:0] : offset_q;
        sel_we     = (state == ST_IDLE) ? req_we : we_q;
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3    (sel_funct3),
        .offset    (sel_offset),
        .we        (sel_we),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .illegal   (illegal),
        .misalign  (misalign),
        .wstrb     (wstrb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Control FSM with every output registered. resp_valid defaults low so
    // the response is a single-cycle strobe. The wait counter only moves in
    // MEM; mem_ready wins over the timeout on the final allowed cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_cause <= CAUSE_NONE;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            offset_q   <= '0;
            wait_cnt   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        offset_q  <= req_addr[OFF_W-1:0];
                        if (illegal) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_cause <= CAUSE_ILLEGAL;
                            resp_rdata <= '0;
                        end else if (misalign) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_cause <= CAUSE_MISALIGN;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_MEM;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= wdata_rep;
                            mem_wstrb <= wstrb;
                            wait_cnt  <= '0;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state      <= ST_RESP;
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_cause <= CAUSE_NONE;
                        resp_rdata <= we_q ? '0 : rdata_ext;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state      <= ST_RESP;
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_cause <= CAUSE_TIMEOUT;
                        resp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_cause <= CAUSE_NONE;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu. A 32-bit and a 64-bit instance are driven
// in lockstep from the same stimulus; each is compared against a byte-level
// reference model and, for the directed table, against hand-computed values.
module tb_mem_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    logic        rr32, rv32, re32, mv32, mwe32;
    logic [31:0] rd32, ma32, mw32;
    logic [1:0]  rc32;
    logic [3:0]  ms32;

    logic        rr64, rv64, re64, mv64, mwe64;
    logic [63:0] rd64, mw64;
    logic [31:0] ma64;
    logic [1:0]  rc64;
    logic [7:0]  ms64;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          wait_cycles;
        logic [1:0]  cause32;
        logic [63:0] rdata32;
        logic [1:0]  cause64;
        logic [63:0] rdata64;
    } vec_t;

    typedef struct {
        int          resp_cycle;
        int          resp_count;
        int          mv_count;
        int          rr_cycle;
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        we;
        bit          unstable;
    } res_t;

    typedef struct {
        int          resp_cycle;
        int          mv_count;
        logic [1:0]  cause;
        logic [63:0] rdata;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [31:0] addr;
        logic        we;
    } exp_t;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rr32), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_rdata(rd32), .resp_err(re32), .resp_cause(rc32),
        .mem_valid(mv32), .mem_ready(mem_ready), .mem_we(mwe32), .mem_addr(ma32),
        .mem_wdata(mw32), .mem_wstrb(ms32), .mem_rdata(mem_rdata[31:0])
    );

    mem_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(rr64), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rd64), .resp_err(re64), .resp_cause(rc64),
        .mem_valid(mv64), .mem_ready(mem_ready), .mem_we(mwe64), .mem_addr(ma64),
        .mem_wdata(mw64), .mem_wstrb(ms64), .mem_rdata(mem_rdata)
    );

    // Reference model: works byte by byte from access size and offset.
    function automatic exp_t model(input int xlen, input vec_t v);
        exp_t        e;
        int          nb, off, size;
        bit          uns, ill, mis;
        logic [63:0] rd, val;
        nb   = xlen / 8;
        off  = int'(v.addr[2:0]) % nb;
        size = 1 << v.funct3[1:0];
        uns  = v.funct3[2];
        ill  = (v.funct3 == 3'b111) || (v.we && uns) ||
               ((xlen == 32) && ((size == 8) || (v.funct3 == 3'b110)));
        mis  = (off % size) != 0;
        e = '{default: 0};
        if (ill) begin
            e.cause = 2'd3;
            e.resp_cycle = 1;
        end else if (mis) begin
            e.cause = 2'd1;
            e.resp_cycle = 1;
        end else begin
            e.addr = v.addr - 32'(off);
            e.we   = v.we;
            if (v.wait_cycles >= TIMEOUT) begin
                e.cause = 2'd2;
                e.resp_cycle = TIMEOUT + 1;
                e.mv_count = TIMEOUT;
            end else begin
                e.cause = 2'd0;
                e.resp_cycle = 2 + v.wait_cycles;
                e.mv_count = v.wait_cycles + 1;
            end
            for (int i = 0; i < nb; i++) begin
                e.wstrb[i] = !v.we || ((i >= off) && (i < off + size));
                e.wdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
            end
            if (!v.we && (e.cause == 2'd0)) begin
                rd  = (xlen == 32) ? {32'b0, v.rdata[31:0]} : v.rdata;
                val = '0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = rd[8*(off+i) +: 8];
                if (!uns && (size < 8) && val[8*size-1]) begin
                    for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
                end
                if (xlen == 32) val[63:32] = '0;
                e.rdata = val;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic sample(input int c, input logic rv, input logic [63:0] rd, input logic err,
                          input logic [1:0] cause, input logic mv, input logic [31:0] ma,
                          input logic [63:0] mw, input logic [7:0] ms, input logic mwe,
                          input logic rr, inout res_t r);
        if (rv) begin
            r.resp_count++;
            if (r.resp_cycle < 0) begin
                r.resp_cycle = c;
                r.rdata = rd;
                r.err = err;
                r.cause = cause;
            end
        end
        if (mv) begin
            r.mv_count++;
            if (r.mv_count == 1) begin
                r.addr = ma; r.wdata = mw; r.wstrb = ms; r.we = mwe;
            end else if ((ma !== r.addr) || (mw !== r.wdata) || (ms !== r.wstrb) || (mwe !== r.we)) begin
                r.unstable = 1'b1;
            end
        end
        if (rr && (r.resp_cycle >= 0) && (r.rr_cycle < 0) && (c > r.resp_cycle)) r.rr_cycle = c;
    endtask

    // Issues one request to both instances and records what each did over a
    // fixed window measured in cycles after acceptance.
    task automatic applyStimulus(input vec_t v, output res_t r32, output res_t r64);
        int guard = 0;
        r32 = '{resp_cycle: -1, rr_cycle: -1, default: 0};
        r64 = '{resp_cycle: -1, rr_cycle: -1, default: 0};
        while (!(rr32 && rr64) && (guard < 40)) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("idle_wait_expired", 64'(guard >= 40), 64'd0);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.funct3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_rdata  = v.rdata;
        mem_ready  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            sample(c, rv32, {32'b0, rd32}, re32, rc32, mv32, ma32, {32'b0, mw32}, {4'b0, ms32}, mwe32, rr32, r32);
            sample(c, rv64, rd64, re64, rc64, mv64, ma64, mw64, ms64, mwe64, rr64, r64);
            mem_ready = (c == 1 + v.wait_cycles);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic checkTxn(input string tag, input exp_t e, input res_t r);
        checkOutput({tag, "resp_cycle"}, 64'(r.resp_cycle), 64'(e.resp_cycle));
        checkOutput({tag, "resp_count"}, 64'(r.resp_count), 64'd1);
        checkOutput({tag, "err"}, 64'(r.err), 64'(e.cause != 2'd0));
        checkOutput({tag, "cause"}, 64'(r.cause), 64'(e.cause));
        checkOutput({tag, "rdata"}, r.rdata, e.rdata);
        checkOutput({tag, "mem_valid_cycles"}, 64'(r.mv_count), 64'(e.mv_count));
        checkOutput({tag, "req_ready_cycle"}, 64'(r.rr_cycle), 64'(e.resp_cycle + 1));
        if (e.mv_count > 0) begin
            checkOutput({tag, "mem_addr"}, 64'(r.addr), 64'(e.addr));
            checkOutput({tag, "mem_wstrb"}, 64'(r.wstrb), 64'(e.wstrb));
            checkOutput({tag, "mem_we"}, 64'(r.we), 64'(e.we));
            checkOutput({tag, "mem_stable"}, 64'(r.unstable), 64'd0);
            if (e.we) checkOutput({tag, "mem_wdata"}, r.wdata, e.wdata);
        end
    endtask

    task automatic runVec(input string tag, input vec_t v, input bit use_tbl);
        res_t r32, r64;
        applyStimulus(v, r32, r64);
        checkTxn({tag, "/x32/"}, model(32, v), r32);
        checkTxn({tag, "/x64/"}, model(64, v), r64);
        if (use_tbl) begin
            checkOutput({tag, "/x32/tbl_cause"}, 64'(r32.cause), 64'(v.cause32));
            checkOutput({tag, "/x32/tbl_rdata"}, r32.rdata, v.rdata32);
            checkOutput({tag, "/x64/tbl_cause"}, 64'(r64.cause), 64'(v.cause64));
            checkOutput({tag, "/x64/tbl_rdata"}, r64.rdata, v.rdata64);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   rv_seen;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

        // Directed vectors: we, funct3, addr, wdata, rdata, waits, cause32, rdata32, cause64, rdata64
        vecs.push_back('{1'b0, 3'b000, 32'h103, 64'h0, 64'h80FF_0000, 0, 2'd0, 64'hFFFF_FF80, 2'd0, 64'hFFFF_FFFF_FFFF_FF80});
        vecs.push_back('{1'b1, 3'b001, 32'h202, 64'h1234_ABCD, 64'h0, 0, 2'd0, 64'h0, 2'd0, 64'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h101, 64'h0, 64'h0, 0, 2'd1, 64'h0, 2'd1, 64'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h0, 64'h0, 64'h0, 20, 2'd2, 64'h0, 2'd2, 64'h0});
        vecs.push_back('{1'b0, 3'b110, 32'h14, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 2'd3, 64'h0, 2'd0, 64'hDEAD_BEEF});
        vecs.push_back('{1'b0, 3'b000, 32'h40, 64'h0, 64'h7F, TIMEOUT - 1, 2'd0, 64'h7F, 2'd0, 64'h7F});
        vecs.push_back('{1'b0, 3'b011, 32'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 2'd3, 64'h0, 2'd0, 64'h8123_4567_89AB_CDEF});
        vecs.push_back('{1'b0, 3'b111, 32'h0, 64'h0, 64'h0, 0, 2'd3, 64'h0, 2'd3, 64'h0});
        vecs.push_back('{1'b1, 3'b101, 32'h1, 64'hFFFF, 64'h0, 0, 2'd3, 64'h0, 2'd3, 64'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h6, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 2'd0, 64'hFFFF_9ABC, 2'd0, 64'h1234});
        vecs.push_back('{1'b0, 3'b100, 32'h7, 64'h0, 64'h1234_5678_9ABC_DEF0, 1, 2'd0, 64'h9A, 2'd0, 64'h12});
        vecs.push_back('{1'b1, 3'b011, 32'h10, 64'h0102_0304_0506_0708, 64'h0, 0, 2'd3, 64'h0, 2'd0, 64'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 3, 2'd0, 64'h9ABC_DEF0, 2'd0, 64'hFFFF_FFFF_9ABC_DEF0});
        vecs.push_back('{1'b1, 3'b000, 32'h3, 64'h5A, 64'h0, 2, 2'd0, 64'h0, 2'd0, 64'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h4, 64'h0, 64'h0, 0, 2'd3, 64'h0, 2'd1, 64'h0});

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/x32/req_ready", 64'(rr32), 64'd0);
        checkOutput("reset/x64/req_ready", 64'(rr64), 64'd0);
        checkOutput("reset/x32/resp", {rv32, re32, rc32, rd32}, 64'd0);
        checkOutput("reset/x64/resp", {rv64, re64, rc64}, 64'd0);
        checkOutput("reset/x64/resp_rdata", rd64, 64'd0);
        checkOutput("reset/x32/mem", {mv32, mwe32, ms32, mw32}, 64'd0);
        checkOutput("reset/x64/mem", {mv64, mwe64, ms64}, 64'd0);
        checkOutput("reset/x64/mem_addr_wdata", {ma64, mw64[31:0]} | {32'b0, mw64[63:32]} | {ma32, 32'b0}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("after_reset/x32/req_ready", 64'(rr32), 64'd1);
        checkOutput("after_reset/x64/req_ready", 64'(rr64), 64'd1);

        foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i], 1'b1);

        // Reset asserted while both instances wait in MEM
        v = '{1'b0, 3'b010, 32'h0, 64'h0, 64'h0, 0, 2'd0, 64'h0, 2'd0, 64'h0};
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.funct3; req_addr = v.addr; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("midrst/x32/mem_valid_before", 64'(mv32), 64'd1);
        checkOutput("midrst/x64/mem_valid_before", 64'(mv64), 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst/x32/mem_valid_after", 64'(mv32), 64'd0);
        checkOutput("midrst/x64/mem_valid_after", 64'(mv64), 64'd0);
        checkOutput("midrst/x32/req_ready", 64'(rr32), 64'd0);
        reset = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ready = (c == 2);
            if (rv32 || rv64) rv_seen++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        checkOutput("midrst/resp_valid_seen", 64'(rv_seen), 64'd0);

        // Randomised requests, checked against the model only
        for (int n = 0; n < 60; n++) begin
            v = '{default: 0};
            v.we     = 1'($urandom_range(0, 1));
            v.funct3 = 3'($urandom_range(0, 7));
            v.addr   = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[2:0] = 3'b000;
            v.wdata  = {$urandom, $urandom};
            v.rdata  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: v.wait_cycles = 0;
                5, 6:          v.wait_cycles = int'($urandom_range(1, 3));
                7:             v.wait_cycles = TIMEOUT - 1;
                8:             v.wait_cycles = TIMEOUT;
                default:       v.wait_cycles = TIMEOUT + 1;
            endcase
            runVec($sformatf("rnd%0d", n), v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit between the multi-cycle core's control FSM and a memory port with a valid/ready handshake. It adds behaviour the core's memory path lacks:
- wait-state tolerance;
- byte-strobe stores instead of read-modify-write;
- sign/zero extension on loads;
- misalignment and illegal-size detection;
- a watchdog timeout.

Width is generic for XLEN 32 or 64.

## Interface
- XLEN, 32: data width; legal values 32, 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 16: maximum cycles waiting for mem_ready; legal range 2..255.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  request failed.
- resp_cause  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal funct3.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory completes the request this cycle.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  XLEN/8  byte enables; all ones for loads.
- mem_rdata  in  XLEN  full word returned by memory.

## Operation
- FSM states: IDLE, MEM, RESP. Reset forces IDLE.
- IDLE: req_ready=1. On req_valid && req_ready, latch we, funct3 and addr offset, then check the request:
  - illegal funct3 (BU/HU/WU stores, D or WU when XLEN=32, or 111) -> RESP, cause 3;
  - misaligned (H with offset bit0 set, W offset not a multiple of 4, D offset not 0) -> RESP, cause 1;
  - otherwise register mem_addr, mem_wdata, mem_wstrb and mem_we, then go to MEM.
- Illegal funct3 takes priority over misaligned.
- MEM:
  - mem_valid=1 and all mem_* outputs held stable.
  - The wait counter starts at 0 on entry and increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata; for loads, extract the lane at the offset and sign-extend (B/H/W) or zero-extend (BU/HU/WU/D); go to RESP, cause 0.
  - Counter reaches TIMEOUT-1 with mem_ready=0: go to RESP, cause 2. mem_valid drops the next cycle, and any later mem_ready is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The core cannot stall the response; it must accept it.
- Store lanes:
  - byte data replicated XLEN/8 times; wstrb = 1 << offset;
  - half data replicated; wstrb = 2'b11 << offset;
  - word data duplicated when XLEN=64; wstrb = 4'hF << offset;
  - D stores: all strobes set.
- Arithmetic: offset = addr[log2(XLEN/8)-1:0]. Lane shift = offset*8 bits. Shifts stay within XLEN with no wrap.

## Timing
- Reset values (held while reset=1): req_ready=0; resp_valid, resp_err, resp_cause, resp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb all 0. req_ready rises the first cycle after reset deasserts.
- Zero-wait-state access: request accepted at edge N; mem_valid high in cycle N+1; resp_valid in cycle N+2; req_ready in cycle N+3. Throughput is one access per 3 cycles.
- Each wait state adds 1 cycle. A timeout gives resp_valid TIMEOUT+1 cycles after acceptance.
- Error path (cause 1 or 3): resp_valid in cycle N+1; mem_valid never asserts.
- Reset mid-MEM: mem_valid is 0 the cycle after reset is sampled, and no response is generated.
- req_valid is ignored outside IDLE. Requests are not queued.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (LSU_B … LSU_WU);
  - cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_TIMEOUT, CAUSE_ILLEGAL);
  - FSM state encoding.
- Sub-module lsu_align: purely combinational; computes misalign/illegal flags, wstrb, replicated wdata and extended rdata from funct3, offset and XLEN. mem_lsu holds the FSM, wait counter and output registers.

## Test plan
- XLEN=32, LB at 0x103, mem_rdata=0x80FF_0000, mem_ready at once -> resp_rdata=0xFFFF_FF80, resp_valid 2 cycles after acceptance.
- SH at 0x202, wdata=0x1234_ABCD -> mem_addr=0x200, mem_wdata=0xABCD_ABCD, mem_wstrb=4'b1100, mem_we=1.
- LW at 0x101 -> resp_err=1, cause=1 one cycle after acceptance; mem_valid stays 0.
- LHU at 0x0, mem_ready held low, TIMEOUT=16 -> resp_err=1, cause=2 at cycle 17; mem_valid low from then on.
- XLEN=64, LWU at 0x14, mem_rdata=0xDEAD_BEEF_0000_0000 -> resp_rdata=0x0000_0000_DEAD_BEEF. Same bench with reset asserted mid-MEM -> mem_valid=0 next cycle, no resp_valid.
